// File: rtl/digital_fll_controller.sv
// rtl/digital_fll_controller.sv - frequency-locked-loop trim controller for a ring-oscillator DCO
module digital_fll_controller #(
  parameter int TRIM_BITS  = 26,
  parameter int DIV_BITS   = 5,
  parameter int CNT_BITS   = 8,
  parameter int LOCK_COUNT = 4,
  parameter int TOL        = 1,
  parameter int TRIM_INIT  = 13
) (
  input  logic                           clock,
  input  logic                           resetb,
  input  logic                           enable,
  input  logic                           dco,
  input  logic                           osc,
  input  logic [DIV_BITS-1:0]            div,
  input  logic [TRIM_BITS-1:0]           ext_trim,
  output logic [TRIM_BITS-1:0]           trim,
  output logic [$clog2(TRIM_BITS+1)-1:0] tval,
  output logic                           locked,
  output logic                           osc_lost
);

  localparam int TVW = $clog2(TRIM_BITS + 1);
  localparam int LCW = $clog2(LOCK_COUNT + 1);
  localparam int CW  = CNT_BITS + 1;

  localparam logic [CNT_BITS-1:0] CNT_MAX   = {CNT_BITS{1'b1}};
  localparam logic [TVW-1:0]      TVAL_INIT = TVW'(TRIM_INIT);
  localparam logic [TVW-1:0]      TVAL_MAX  = TVW'(TRIM_BITS);
  localparam logic [LCW-1:0]      LOCK_MAX  = LCW'(LOCK_COUNT);
  localparam logic [CW-1:0]       TOL_W     = CW'(TOL);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    TRACK  = 2'd2,
    LOCKED = 2'd3
  } state_t;

  state_t               state;
  state_t               state_n;
  logic                 osc_s1;
  logic                 osc_s2;
  logic                 osc_hist;
  logic                 rise;
  logic [CNT_BITS-1:0]  cnt;
  logic [CNT_BITS-1:0]  meas;
  logic [CW-1:0]        meas_w;
  logic [CW-1:0]        div_w;
  logic                 too_fast;
  logic                 too_slow;
  logic                 cnt_full;
  logic                 loop_off;
  logic [DIV_BITS-1:0]  div_q;
  logic [TVW-1:0]       tval_n;
  logic [LCW-1:0]       lock_cnt;
  logic [LCW-1:0]       lock_n;
  logic                 lost_n;
  logic [TRIM_BITS-1:0] therm;

  // Bring the reference oscillator into the clock domain and keep one history bit for edge detect.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      osc_s1   <= 1'b0;
      osc_s2   <= 1'b0;
      osc_hist <= 1'b0;
    end else begin
      osc_s1   <= osc;
      osc_s2   <= osc_s1;
      osc_hist <= osc_s2;
    end
  end

  assign rise     = osc_s2 & ~osc_hist;
  assign cnt_full = (cnt == CNT_MAX);
  assign loop_off = !enable || dco || (div == '0);

  // Period counter: restarts on every reference rise, saturates when the reference goes quiet.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= '0;
    end else if (!cnt_full) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Measured period and band comparison, one bit wider than the counter so nothing wraps.
  always_comb begin
    meas     = cnt_full ? CNT_MAX : (cnt + 1'b1);
    meas_w   = {1'b0, meas};
    div_w    = CW'(div);
    too_fast = meas_w > (div_w + TOL_W);
    too_slow = (meas_w + TOL_W) < div_w;
  end

  // Remember the previous divide ratio so a retarget while tracking can drop lock.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      div_q <= '0;
    end else begin
      div_q <= div;
    end
  end

  // Next-state decision: idle override, then retarget, then measurement, then lost reference.
  always_comb begin
    state_n = state;
    tval_n  = tval;
    lock_n  = lock_cnt;
    lost_n  = osc_lost;
    if (loop_off) begin
      state_n = IDLE;
      tval_n  = TVAL_INIT;
      lock_n  = '0;
      lost_n  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_n = ARM;
        end
        ARM: begin
          // The arming rise only restarts the counter; no trim decision is made on it.
          if (rise) begin
            state_n = TRACK;
            lost_n  = 1'b0;
          end else if (cnt_full) begin
            lost_n = 1'b1;
            lock_n = '0;
          end
        end
        TRACK, LOCKED: begin
          if (div != div_q) begin
            state_n = TRACK;
            lock_n  = '0;
          end else if (rise) begin
            lost_n = 1'b0;
            if (too_fast) begin
              if (tval != TVAL_MAX) tval_n = tval + 1'b1;
              lock_n  = '0;
              state_n = TRACK;
            end else if (too_slow) begin
              if (tval != '0) tval_n = tval - 1'b1;
              lock_n  = '0;
              state_n = TRACK;
            end else begin
              if (lock_cnt != LOCK_MAX) lock_n = lock_cnt + 1'b1;
              if (lock_n == LOCK_MAX) state_n = LOCKED;
            end
          end else if (cnt_full) begin
            // Reference vanished: freeze trim and re-arm so the next evaluation sees a clean period.
            lost_n  = 1'b1;
            lock_n  = '0;
            state_n = ARM;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // Loop state register with the lock flag registered alongside the state it reflects.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state    <= IDLE;
      tval     <= TVAL_INIT;
      lock_cnt <= '0;
      osc_lost <= 1'b0;
      locked   <= 1'b0;
    end else begin
      state    <= state_n;
      tval     <= tval_n;
      lock_cnt <= lock_n;
      osc_lost <= lost_n;
      locked   <= (state_n == LOCKED);
    end
  end

  // Thermometer expansion of the binary trim: the lowest tval elements are switched on.
  always_comb begin
    therm = '0;
    for (int i = 0; i < TRIM_BITS; i++) begin
      therm[i] = (TVW'(i) < tval);
    end
  end

  assign trim = dco ? ext_trim : therm;

endmodule

// File: doc/digital_fll_controller.md
DIGITAL_FLL_CONTROLLER -- requirements
Module: digital_fll_controller

Interface
REQ-001 Parameter TRIM_BITS, default 26: ring-oscillator trim width, thermometer code.
REQ-002 Parameter DIV_BITS, default 5: width of the feedback divide ratio.
REQ-003 Parameter CNT_BITS, default 8: width of the period counter; must be greater than DIV_BITS.
REQ-004 Parameter LOCK_COUNT, default 4: consecutive in-band measurements required to declare lock.
REQ-005 Parameter TOL, default 1: in-band tolerance in clock cycles.
REQ-006 Parameter TRIM_INIT, default 13: trim value loaded at reset and in IDLE; range 0..TRIM_BITS.
REQ-007 clock  in  1  DCO output clock; all state is on its rising edge.
REQ-008 resetb  in  1  reset, asynchronous assert, active-low.
REQ-009 enable  in  1  controller enable.
REQ-010 dco  in  1  DCO mode: apply ext_trim and idle the loop.
REQ-011 osc  in  1  reference oscillator, asynchronous to clock.
REQ-012 div  in  DIV_BITS  target clock cycles per osc period.
REQ-013 ext_trim  in  TRIM_BITS  external trim, used in DCO mode.
REQ-014 trim  out  TRIM_BITS  trim applied to the ring oscillator.
REQ-015 tval  out  clog2(TRIM_BITS+1)  current binary trim value.
REQ-016 locked  out  1  frequency lock indicator.
REQ-017 osc_lost  out  1  no osc edge seen within the counter range.

Function
REQ-018 osc shall pass through a 2-flop synchronizer plus one history flop; rise = sync2 & ~hist.
REQ-019 cnt shall clear to 0 on a rise, otherwise increment, saturating at all-ones.
REQ-020 On a rise, meas = cnt+1 (saturating), the number of clock periods since the previous rise.
REQ-021 FSM states: IDLE, ARM, TRACK, LOCKED.
REQ-022 Any state -> IDLE when enable=0, dco=1, or div=0.
REQ-023 IDLE -> ARM when enable=1, dco=0 and div!=0.
REQ-024 ARM -> TRACK on the first rise; that rise only restarts cnt and makes no trim update.
REQ-025 In TRACK/LOCKED, each rise evaluates meas.
REQ-026 If meas > div+TOL, tval shall increment (clock too fast), saturating at TRIM_BITS.
REQ-027 If meas+TOL < div, tval shall decrement (clock too slow), saturating at 0.
REQ-028 Otherwise meas is in-band: tval is held and lock_cnt increments, saturating at LOCK_COUNT.
REQ-029 Out-of-band measurement shall clear lock_cnt; LOCKED -> TRACK.
REQ-030 TRACK -> LOCKED when lock_cnt reaches LOCK_COUNT.
REQ-031 tval, lock_cnt and state shall update on the same edge at which the rise is sampled.
REQ-032 Compare arithmetic is unsigned and at least CNT_BITS+1 wide, so no overflow occurs.
REQ-033 A change of div while in TRACK/LOCKED shall clear lock_cnt and go to TRACK; tval is held.
REQ-034 cnt reaching all-ones in ARM/TRACK/LOCKED shall set osc_lost, clear lock_cnt and go to ARM; tval is frozen.
REQ-035 osc_lost shall clear on the next rise.
REQ-036 In IDLE, tval shall be held at TRIM_INIT, lock_cnt=0 and osc_lost=0.
REQ-037 trim shall be combinational: ext_trim when dco=1, else thermometer(tval) with trim[i]=1 for i<tval.
REQ-038 locked shall be 1 exactly when the state is LOCKED, and shall be registered.

Reset
REQ-039 While resetb=0: state=IDLE, tval=TRIM_INIT, cnt=0, lock_cnt=0, locked=0, osc_lost=0, synchronizer flops=0.
REQ-040 The first post-reset evaluation shall require a full ARM cycle, i.e. at least two osc rises.

Verification (defaults, CNT_BITS=8)
REQ-041 resetb=0 -> trim=0x0001FFF, tval=13, locked=0, osc_lost=0; same after a mid-TRACK reset pulse.
REQ-042 div=8, osc period 10 clocks -> first rise arms; each later rise increments tval (14, 15, ...) until 26, then holds at 26.
REQ-043 div=8, period 8 clocks -> locked=1 after the 4th in-band rise following arm; one 12-clock period -> locked=0 and tval+1 on that edge.
REQ-044 dco=1, ext_trim=0x3FFFFFF -> trim=0x3FFFFFF in the same cycle, locked=0, tval=13; dco back to 0 -> ARM.
REQ-045 osc stopped while LOCKED -> osc_lost=1 at cnt=255, locked=0, tval unchanged; osc restarts -> osc_lost=0 on the first rise.
REQ-046 div=20, period 5 clocks from tval=1 -> tval 0 and holds; div=0 at any time -> IDLE, tval=13.
